ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter COUNT_W, default 8, width of keystroke counter.
REQ-002 Parameter CODE_W, default 8, width of scan-code byte (fixed 8; present for package alignment).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ready  input  1  PS/2 receiver FIFO non-empty.
REQ-006 ps2_byte  input  8  FIFO head byte, valid while ready=1.
REQ-007 overflow  input  1  receiver FIFO overflow flag.
REQ-008 nextdata_n  output  1  active-low pop strobe to receiver FIFO, registered.
REQ-009 key_code  output  8  last make code accepted (without prefixes).
REQ-010 key_ext  output  1  key_code was E0-prefixed.
REQ-011 key_down  output  1  key in key_code currently held.
REQ-012 key_ascii  output  8  ASCII of key_code (see Configuration).
REQ-013 press_count  output  COUNT_W  number of distinct key presses, wrapping.
REQ-014 event_valid  output  1  one-cycle pulse on every press or release event.
REQ-015 ovf_sticky  output  1  latched overflow indication.

Function
REQ-016 Fetch FSM states IDLE, POP, GAP; IDLE->POP when ready=1, capturing ps2_byte that cycle.
REQ-017 POP: nextdata_n=0 for exactly one cycle, then GAP; GAP: one cycle, ready ignored, then IDLE.
REQ-018 nextdata_n SHALL be 1 in IDLE and GAP; at most one pop per 3 cycles; no byte consumed twice.
REQ-019 Captured byte 8'hE0 sets ext_pend; 8'hF0 sets brk_pend; neither generates an event.
REQ-020 Other byte with brk_pend=0 is a make: if key_down=0 or (byte,ext_pend) differs from (key_code,key_ext), load key_code/key_ext, set key_down, increment press_count, pulse event_valid.
REQ-021 Make equal to held (key_code,key_ext) with key_down=1 is typematic repeat: no count, no event.
REQ-022 Byte with brk_pend=1 is a break: if it matches (key_code,key_ext) and key_down=1, clear key_down and pulse event_valid; else ignore; key_code/key_ext retained.
REQ-023 ext_pend and brk_pend clear after any non-prefix byte; E0 F0 xx order accepted; duplicate prefixes keep flags set.
REQ-024 Registered outputs update in the cycle after capture (1-cycle latency from IDLE->POP edge); event_valid aligned with that update.
REQ-025 press_count wraps 2^COUNT_W-1 -> 0 without saturation.
REQ-026 ovf_sticky sets when overflow=1 on any cycle; clears only on reset.

Reset
REQ-027 rst=1 on a clock edge: FSM->IDLE, nextdata_n=1, key_code=0, key_ext=0, key_down=0, key_ascii=0, press_count=0, event_valid=0, ovf_sticky=0, both pending flags 0.
REQ-028 Reset during POP or GAP aborts the pop sequence; a byte already popped is discarded, not replayed.

Configuration
REQ-029 Macro KEY_ASCII_EN defined: key_ascii = ASCII of key_code for non-extended letter/digit/space codes (lowercase), else 0; updated with key_code.
REQ-030 Macro KEY_ASCII_EN undefined: key_ascii tied to 8'h00, lookup not synthesised.

Structure
REQ-031 Package ps2_pkg holds PS2_EXT_CODE=8'hE0, PS2_BRK_CODE=8'hF0, fetch-FSM state enum, CODE_W.
REQ-032 Sub-module ps2_scan2ascii (combinational scan-to-ASCII table), instantiated only under KEY_ASCII_EN.

Verification
REQ-033 Queue 1C -> key_code=1C, key_down=1, press_count=1, event_valid one pulse, key_ascii=61 (with KEY_ASCII_EN).
REQ-034 Queue 1C 1C 1C F0 1C -> press_count=1, two event_valid pulses total, key_down=0 at end.
REQ-035 Queue E0 75 then E0 F0 75 -> key_ext=1, key_code=75, key_down 1 then 0, key_ascii=00.
REQ-036 ready held high with 5 bytes -> nextdata_n low exactly 5 single cycles, each separated by >=2 high cycles.
REQ-037 press_count=FF then new make 32 -> press_count=00; overflow pulse -> ovf_sticky=1 until rst.
REQ-038 rst asserted in POP cycle -> next cycle all outputs at reset values, nextdata_n=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and fetch-FSM state type for the PS/2 key tracker.
package ps2_pkg;

  localparam int         CODE_W       = 8;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to lowercase ASCII lookup.
// Covers letters, digits and space; extended codes map to 0.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              ext,
  output logic [7:0]        ascii
);

  always_comb begin
    ascii = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: ascii = "a";
        8'h32: ascii = "b";
        8'h21: ascii = "c";
        8'h23: ascii = "d";
        8'h24: ascii = "e";
        8'h2B: ascii = "f";
        8'h34: ascii = "g";
        8'h33: ascii = "h";
        8'h43: ascii = "i";
        8'h3B: ascii = "j";
        8'h42: ascii = "k";
        8'h4B: ascii = "l";
        8'h3A: ascii = "m";
        8'h31: ascii = "n";
        8'h44: ascii = "o";
        8'h4D: ascii = "p";
        8'h15: ascii = "q";
        8'h2D: ascii = "r";
        8'h1B: ascii = "s";
        8'h2C: ascii = "t";
        8'h3C: ascii = "u";
        8'h2A: ascii = "v";
        8'h1D: ascii = "w";
        8'h22: ascii = "x";
        8'h35: ascii = "y";
        8'h1A: ascii = "z";
        8'h45: ascii = "0";
        8'h16: ascii = "1";
        8'h1E: ascii = "2";
        8'h26: ascii = "3";
        8'h25: ascii = "4";
        8'h2E: ascii = "5";
        8'h36: ascii = "6";
        8'h3D: ascii = "7";
        8'h3E: ascii = "8";
        8'h46: ascii = "9";
        8'h29: ascii = " ";
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: pops scan bytes from a receiver FIFO and tracks the last key.
// Define KEY_ASCII_EN to build the scan-to-ASCII lookup; otherwise key_ascii is 0.
module ps2_key_tracker #(
  parameter int COUNT_W = 8,
  parameter int CODE_W  = ps2_pkg::CODE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic [CODE_W-1:0]  ps2_byte,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic [CODE_W-1:0]  key_code,
  output logic               key_ext,
  output logic               key_down,
  output logic [7:0]         key_ascii,
  output logic [COUNT_W-1:0] press_count,
  output logic               event_valid,
  output logic               ovf_sticky
);
  import ps2_pkg::*;

  fetch_state_t      state, state_next;
  logic [CODE_W-1:0] byte_q;
  logic              ext_pend, brk_pend;
  logic              is_ext, is_brk, same_key;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ready) state_next = POP;
      POP:     state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe is registered from next-state so it is low for exactly the POP cycle.
  always_ff @(posedge clk) begin
    if (rst) nextdata_n <= 1'b1;
    else     nextdata_n <= (state_next != POP);
  end

  always_ff @(posedge clk) begin
    if (rst)                           byte_q <= '0;
    else if ((state == IDLE) && ready) byte_q <= ps2_byte;
  end

  assign is_ext   = (byte_q == PS2_EXT_CODE);
  assign is_brk   = (byte_q == PS2_BRK_CODE);
  assign same_key = key_down && (byte_q == key_code) && (ext_pend == key_ext);

  // The captured byte is decoded in POP, so a reset during POP drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      press_count <= '0;
      event_valid <= 1'b0;
      ovf_sticky  <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      if (overflow) ovf_sticky <= 1'b1;
      if (state == POP) begin
        if (is_ext) begin
          ext_pend <= 1'b1;
        end else if (is_brk) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (!brk_pend) begin
            if (!same_key) begin
              key_code    <= byte_q;
              key_ext     <= ext_pend;
              key_down    <= 1'b1;
              press_count <= press_count + COUNT_W'(1);
              event_valid <= 1'b1;
            end
          end else if (same_key) begin
            key_down    <= 1'b0;
            event_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef KEY_ASCII_EN
  ps2_scan2ascii u_scan2ascii (
    .code  (key_code),
    .ext   (key_ext),
    .ascii (key_ascii)
  );
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: queue-fed FIFO, behavioural model, per-cycle compare.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       nextdata_n, key_ext, key_down, event_valid, ovf_sticky;
  logic [7:0] key_code, key_ascii, press_count;

  int checks = 0;
  int errors = 0;

  ps2_key_tracker #(.COUNT_W(8), .CODE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .ps2_byte    (ps2_byte),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_down    (key_down),
    .key_ascii   (key_ascii),
    .press_count (press_count),
    .event_valid (event_valid),
    .ovf_sticky  (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Receiver FIFO seen by the DUT, and the model's own copy of the byte stream.
  logic [7:0] env_fifo[$];
  logic [7:0] mdl_fifo[$];

  // Model: a byte is taken when the fetcher is free, its effect lands one cycle later,
  // and the fetcher stays busy for three cycles per byte.
  logic       m_nd = 1'b1;
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0, m_down = 1'b0, m_ev = 1'b0, m_ovf = 1'b0;
  logic       m_extp = 1'b0, m_brkp = 1'b0;
  logic [7:0] m_count = 8'h00;
  int         m_busy = 0;
  logic       m_have = 1'b0;
  logic [7:0] m_byte = 8'h00;

  logic chk_en = 1'b0;
  int   ev_seen = 0;
  int   pops = 0;
  int   gap_run = 0;
  int   min_gap = 1000;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

`ifdef KEY_ASCII_EN
  function automatic logic [7:0] asciiOf(input logic [7:0] c, input logic e);
    string      keys = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    logic [7:0] codes [37] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                               8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29};
    if (e) return 8'h00;
    for (int i = 0; i < 37; i++) if (codes[i] == c) return keys[i];
    return 8'h00;
  endfunction
`endif

  task automatic modelApply(input logic [7:0] b);
    if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0) m_brkp = 1'b1;
    else begin
      if (!m_brkp) begin
        if (!(m_down && b == m_code && m_extp == m_ext)) begin
          m_code  = b;
          m_ext   = m_extp;
          m_down  = 1'b1;
          m_count = m_count + 8'd1;
          m_ev    = 1'b1;
        end
      end else if (m_down && b == m_code && m_extp == m_ext) begin
        m_down = 1'b0;
        m_ev   = 1'b1;
      end
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end
  endtask

  task automatic modelStep();
    m_ev = 1'b0;
    if (rst) begin
      m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_count = 8'h00; m_ovf = 1'b0;
      m_extp = 1'b0; m_brkp = 1'b0; m_busy = 0; m_have = 1'b0; m_nd = 1'b1;
    end else begin
      if (overflow) m_ovf = 1'b1;
      if (m_have) begin
        modelApply(m_byte);
        m_have = 1'b0;
      end
      if (m_busy > 0) m_busy--;
      else if (mdl_fifo.size() > 0) begin
        m_byte = mdl_fifo.pop_front();
        m_have = 1'b1;
        m_busy = 2;
      end
      m_nd = !m_have;
    end
  endtask

  task automatic driveInputs();
    ready    = (env_fifo.size() > 0);
    ps2_byte = ready ? env_fifo[0] : 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    env_fifo.push_back(b);
    mdl_fifo.push_back(b);
    driveInputs();
  endtask

  // The FIFO pops on each edge that sees the strobe low.
  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    if (nextdata_n === 1'b0) begin
      if (pops > 0 && gap_run < min_gap) min_gap = gap_run;
      pops++;
      gap_run = 0;
      if (env_fifo.size() > 0) void'(env_fifo.pop_front());
    end else begin
      gap_run++;
    end
    driveInputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput();
    logic [7:0] ea;
`ifdef KEY_ASCII_EN
    ea = asciiOf(m_code, m_ext);
`else
    ea = 8'h00;
`endif
    cmp("nextdata_n",  nextdata_n,  m_nd);
    cmp("key_code",    key_code,    m_code);
    cmp("key_ext",     key_ext,     m_ext);
    cmp("key_down",    key_down,    m_down);
    cmp("key_ascii",   key_ascii,   ea);
    cmp("press_count", press_count, m_count);
    cmp("event_valid", event_valid, m_ev);
    cmp("ovf_sticky",  ovf_sticky,  m_ovf);
    if (event_valid === 1'b1) ev_seen++;
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  initial begin
    logic found;

    rst = 1'b1;
    driveInputs();
    run(2);
    chk_en = 1'b1;
    cmp("rst_nextdata_n", nextdata_n, 1);
    cmp("rst_key_code", key_code, 0);
    cmp("rst_press_count", press_count, 0);
    cmp("rst_key_down", key_down, 0);
    cmp("rst_ovf", ovf_sticky, 0);
    rst = 1'b0;
    run(2);

    // Single make of 'a'.
    ev_seen = 0;
    applyStimulus(8'h1C);
    run(8);
    cmp("a_code", key_code, 8'h1C);
    cmp("a_down", key_down, 1);
    cmp("a_count", press_count, 1);
    cmp("a_events", ev_seen, 1);
`ifdef KEY_ASCII_EN
    cmp("a_ascii", key_ascii, 8'h61);
`else
    cmp("a_ascii", key_ascii, 8'h00);
`endif
    cmp("model_a_count", m_count, 1);

    // Typematic repeats then release, with ready held high the whole burst.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    ev_seen = 0; pops = 0; gap_run = 0; min_gap = 1000;
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    run(20);
    cmp("rep_count", press_count, 1);
    cmp("rep_events", ev_seen, 2);
    cmp("rep_down", key_down, 0);
    cmp("rep_pops", pops, 5);
    cmp("rep_gap_ge2", (min_gap >= 2), 1);
    cmp("model_rep_down", m_down, 0);

    // Extended key press and release.
    ev_seen = 0;
    applyStimulus(8'hE0); applyStimulus(8'h75);
    run(10);
    cmp("ext_key", key_ext, 1);
    cmp("ext_code", key_code, 8'h75);
    cmp("ext_down", key_down, 1);
    cmp("ext_count", press_count, 2);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    run(12);
    cmp("ext_up", key_down, 0);
    cmp("ext_keep", key_ext, 1);
    cmp("ext_ascii", key_ascii, 8'h00);
    cmp("ext_events", ev_seen, 2);

    // Drive the counter to FF, then one more distinct make wraps it.
    for (int i = 0; i < 253; i++) applyStimulus((i % 2 == 0) ? 8'h16 : 8'h1E);
    run(253 * 3 + 10);
    cmp("wrap_ff", press_count, 8'hFF);
    cmp("model_wrap_ff", m_count, 8'hFF);
    applyStimulus(8'h32);
    run(8);
    cmp("wrap_00", press_count, 8'h00);
    cmp("wrap_code", key_code, 8'h32);

    // Overflow latch.
    overflow = 1'b1;
    run(1);
    overflow = 1'b0;
    run(4);
    cmp("ovf_set", ovf_sticky, 1);

    // Reset landing on the POP cycle discards the popped byte.
    applyStimulus(8'h2B);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (nextdata_n === 1'b0) found = 1'b1;
    end
    cmp("pop_seen", found, 1);
    rst = 1'b1;
    run(1);
    cmp("popr_nextdata_n", nextdata_n, 1);
    cmp("popr_code", key_code, 0);
    cmp("popr_down", key_down, 0);
    cmp("popr_count", press_count, 0);
    cmp("popr_ovf", ovf_sticky, 0);
    cmp("popr_event", event_valid, 0);
    rst = 1'b0;
    ev_seen = 0;
    run(10);
    cmp("popr_no_replay", ev_seen, 0);
    cmp("popr_count_after", press_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
